// File: rtl/fft_pkg.sv
// Shared FFT datapath types: loader/core state encoding and
// the address bit-reverse helper used across the FFT stages.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic logic [15:0] bitrev(
    input logic [15:0] x,
    input int          w
  );
    logic [15:0] y;
    y = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < w) y[i] = x[w-1-i];
    end
    return y;
  endfunction

endpackage

// File: rtl/fft_input_loader_if.sv
// Sample stream into the FFT loader: valid/ready with a
// packed {real, imag} complex sample.
interface fft_input_loader_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic [W-1:0] in_samp;
  logic         in_ready;

  modport master (
    output in_valid,
    output in_samp,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_samp,
    output in_ready
  );
endinterface

// File: rtl/fft_bitrev.sv
// Combinational bit reversal of an FFT memory address.
// Pure wiring; no logic levels.
module fft_bitrev #(
  parameter int W = 5
) (
  input  logic [W-1:0] i_x,
  output logic [W-1:0] o_y
);
  for (genvar g = 0; g < W; g++) begin : g_rev
    assign o_y[g] = i_x[W-1-g];
  end
endmodule

// File: rtl/fft_input_loader.sv
// FFT front end: pairs streamed samples and writes them two at a
// time into working memory at bit-reversed addresses.
module fft_input_loader
  import fft_pkg::*;
#(
  parameter int N             = 32,
  parameter int word_size     = 16,
  parameter int address_width = $clog2(N)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  fft_input_loader_if.slave        s_in,
  input  logic                     core_ack,
  output logic [address_width-1:0] out_addr1,
  output logic [address_width-1:0] out_addr2,
  output logic [2*word_size-1:0]   out_samp1,
  output logic [2*word_size-1:0]   out_samp2,
  output logic                     wr_en,
  output logic                     load_done,
  output logic                     busy
);
  localparam int AW = address_width;
  localparam int DW = 2 * word_size;
  localparam logic [AW-1:0] MSB = AW'(1) << (AW - 1);

  state_t          r_state;
  logic [AW-1:0]   r_count;
  logic [DW-1:0]   r_pair;
  logic            r_ack;
  logic            r_done_seen;

  logic            w_acc;
  logic            w_last;
  logic [AW-1:0]   w_base;
  logic [AW-1:0]   w_rev;

  assign s_in.in_ready = (r_state == LOAD);
  assign w_acc  = s_in.in_valid & s_in.in_ready;
  assign w_last = (r_count == AW'(N - 1));
  // even index of the current pair; its reverse has MSB clear
  assign w_base = {r_count[AW-1:1], 1'b0};

  fft_bitrev #(.W(AW)) u_rev (
    .i_x (w_base),
    .o_y (w_rev)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_pair      <= '0;
      r_ack       <= 1'b0;
      r_done_seen <= 1'b0;
      out_addr1   <= '0;
      out_addr2   <= '0;
      out_samp1   <= '0;
      out_samp2   <= '0;
      wr_en       <= 1'b0;
      load_done   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      load_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (en) begin
            r_state     <= LOAD;
            r_count     <= '0;
            r_ack       <= 1'b0;
            r_done_seen <= 1'b0;
            busy        <= 1'b1;
          end
        end
        LOAD: begin
          if (w_acc) begin
            if (!w_last) r_count <= r_count + AW'(1);
            if (!r_count[0]) begin
              r_pair <= s_in.in_samp;
            end else begin
              wr_en     <= 1'b1;
              out_addr1 <= w_rev;
              out_addr2 <= w_rev | MSB;
              out_samp1 <= r_pair;
              out_samp2 <= s_in.in_samp;
            end
            if (w_last) r_state <= HOLD;
          end
        end
        HOLD: begin
          // pulse lands one cycle after the final write
          load_done <= wr_en;
          if (load_done) r_done_seen <= 1'b1;
          if (core_ack) r_ack <= 1'b1;
          if ((core_ack | r_ack) &&
              (load_done | r_done_seen)) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
